pwls_multichannel_osc: RTL and testbench

Time-multiplexed N-channel piecewise-linear oscillator engine: one shared phase/shape/amp datapath services NUM_CH channels in round-robin per sample tick and sums them into a single mixed sample. It generalises the single-channel ALU unit to a parametrised channel count with per-channel phase state, a runtime config write port, a waveform mode per channel and an overrun detector. It sits between the register/SPI front end (cfg port) and the output DAC/PWM stage (out_sample).

---
 rtl/pwls_pkg.sv | 28 ++
 rtl/pwls_wave_shaper.sv | 50 +++++
 rtl/pwls_multichannel_osc.sv | 167 ++++++++++++++++
 tb/tb_pwls_multichannel_osc.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwls_pkg.sv
// -----------------------------------------------------------------------------
// pwls_pkg
// Shared definitions for the piecewise-linear oscillator family:
//   - mode_e       : per-channel waveform mode (saw, triangle, square, off)
//   - CFG_*        : config port address map
//   - phase_bits() : phase accumulator width for a given sample/octave width
// -----------------------------------------------------------------------------
package pwls_pkg;

    typedef enum logic [1:0] {
        MODE_SAW    = 2'd0,
        MODE_TRI    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    localparam logic [1:0] CFG_FREQ  = 2'd0;  // {octave, mantissa}
    localparam logic [1:0] CFG_AMP   = 2'd1;
    localparam logic [1:0] CFG_MODE  = 2'd2;
    localparam logic [1:0] CFG_PHRST = 2'd3;  // force phase to zero

    // Largest increment is {1,mantissa} << (2^OCT_BITS - 1), so the phase
    // needs BITS + 2^OCT_BITS - 1 bits to hold it.
    function automatic int phase_bits(input int bits, input int oct_bits);
        return bits + (1 << oct_bits) - 1;
    endfunction

endpackage

// File: rtl/pwls_wave_shaper.sv
// -----------------------------------------------------------------------------
// pwls_wave_shaper
// Combinational shaping of one phase sample into a scaled contribution.
// Ports:
//   p    in  BITS     top bits of the phase accumulator (unsigned)
//   mode in  mode_e   waveform select
//   amp  in  BITS-2   unsigned amplitude
//   c    out BITS     signed contribution = floor(w * amp / 2^(BITS-2))
// -----------------------------------------------------------------------------
module pwls_wave_shaper
    import pwls_pkg::*;
#(
    parameter int BITS = 12
) (
    input  logic [BITS-1:0]        p,
    input  mode_e                  mode,
    input  logic [BITS-3:0]        amp,
    output logic signed [BITS-1:0] c
);

    localparam int PW = 2 * BITS - 1;

    logic signed [BITS-1:0] w;
    logic [BITS-2:0]        t;

    // Arithmetic shift floors; |w*amp| / 2^(BITS-2) always fits in BITS bits.
    function automatic logic signed [BITS-1:0] scale(input logic signed [BITS-1:0] wv,
                                                      input logic [BITS-3:0] a);
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] shifted;
        prod    = PW'(wv) * $signed({{(PW-(BITS-2)){1'b0}}, a});
        shifted = prod >>> (BITS - 2);
        return shifted[BITS-1:0];
    endfunction

    always_comb begin
        // Fold the upper half of the phase back down to build the triangle.
        t = p[BITS-2:0] ^ {(BITS-1){p[BITS-1]}};
        w = '0;
        case (mode)
            MODE_SAW:    w = {~p[BITS-1], p[BITS-2:0]};
            MODE_TRI:    w = {~t[BITS-2], t[BITS-3:0], 1'b0};
            MODE_SQUARE: w = p[BITS-1] ? {1'b1, {(BITS-1){1'b0}}}
                                       : {1'b0, {(BITS-1){1'b1}}};
            default:     w = '0;
        endcase
        c = scale(w, amp);
    end

endmodule

// File: rtl/pwls_multichannel_osc.sv
// -----------------------------------------------------------------------------
// pwls_multichannel_osc
// Time-multiplexed NUM_CH-channel piecewise-linear oscillator. Each sample
// tick walks every channel through a PHASE cycle (advance phase) and a MIX
// cycle (shape + accumulate), then publishes the mixed sample.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   sample_tick             starts one frame
//   cfg_we/cfg_ch/cfg_addr/cfg_wdata   per-channel config write port
//   out_sample              signed mixed sample, held between frames
//   out_valid               one-cycle pulse when out_sample updates
//   busy                    frame in progress
//   overrun                 sticky: tick arrived while a frame was running
// -----------------------------------------------------------------------------
module pwls_multichannel_osc
    import pwls_pkg::*;
#(
    parameter  int BITS     = 12,
    parameter  int OCT_BITS = 3,
    parameter  int NUM_CH   = 4,
    localparam int CH_BITS  = $clog2(NUM_CH),
    localparam int CFG_W    = OCT_BITS + BITS - 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sample_tick,
    input  logic                        cfg_we,
    input  logic [CH_BITS-1:0]          cfg_ch,
    input  logic [1:0]                  cfg_addr,
    input  logic [CFG_W-1:0]            cfg_wdata,
    output logic signed [BITS+CH_BITS-1:0] out_sample,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int PHASE_BITS = phase_bits(BITS, OCT_BITS);
    localparam int ACC_W      = BITS + CH_BITS;

    typedef enum logic [1:0] {ST_IDLE, ST_PHASE, ST_MIX, ST_OUT} state_e;

    state_e                    state;
    logic [CH_BITS-1:0]        ch;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_sum;

    logic [OCT_BITS-1:0]       octave   [NUM_CH];
    logic [BITS-2:0]           mantissa [NUM_CH];
    logic [BITS-3:0]           amp      [NUM_CH];
    mode_e                     mode     [NUM_CH];
    logic [PHASE_BITS-1:0]     phase    [NUM_CH];

    logic                      cfg_hit;
    logic [OCT_BITS-1:0]       eff_oct;
    logic [BITS-2:0]           eff_man;
    mode_e                     eff_mode;
    logic [PHASE_BITS-1:0]     inc;
    logic [PHASE_BITS-1:0]     phase_next;
    logic [BITS-1:0]           p_cur;
    logic signed [BITS-1:0]    c;

    // A write to the channel being advanced this cycle is used immediately,
    // so software never has to avoid that channel's PHASE slot.
    always_comb begin
        cfg_hit  = cfg_we && (cfg_ch == ch);
        eff_oct  = octave[ch];
        eff_man  = mantissa[ch];
        eff_mode = mode[ch];
        if (cfg_hit && cfg_addr == CFG_FREQ) begin
            eff_oct = cfg_wdata[CFG_W-1 -: OCT_BITS];
            eff_man = cfg_wdata[BITS-2:0];
        end
        if (cfg_hit && cfg_addr == CFG_MODE) begin
            eff_mode = mode_e'(cfg_wdata[1:0]);
        end
        inc        = PHASE_BITS'({1'b1, eff_man}) << eff_oct;
        phase_next = (eff_mode == MODE_OFF) ? phase[ch] : phase[ch] + inc;
    end

    assign p_cur   = phase[ch][PHASE_BITS-1 -: BITS];
    assign acc_sum = acc + ACC_W'(c);

    pwls_wave_shaper #(.BITS(BITS)) u_shaper (
        .p    (p_cur),
        .mode (mode[ch]),
        .amp  (amp[ch]),
        .c    (c)
    );

    // Per-channel configuration and phase state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                octave[i]   <= '0;
                mantissa[i] <= '0;
                amp[i]      <= '0;
                mode[i]     <= MODE_OFF;
                phase[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_we && cfg_ch == CH_BITS'(i)) begin
                    case (cfg_addr)
                        CFG_FREQ: begin
                            octave[i]   <= cfg_wdata[CFG_W-1 -: OCT_BITS];
                            mantissa[i] <= cfg_wdata[BITS-2:0];
                        end
                        CFG_AMP:  amp[i]  <= cfg_wdata[BITS-3:0];
                        CFG_MODE: mode[i] <= mode_e'(cfg_wdata[1:0]);
                        default:  ;
                    endcase
                end
                // Phase reset outranks the PHASE write-back on collision.
                if (cfg_we && cfg_ch == CH_BITS'(i) && cfg_addr == CFG_PHRST) begin
                    phase[i] <= '0;
                end else if (state == ST_PHASE && ch == CH_BITS'(i)) begin
                    phase[i] <= phase_next;
                end
            end
        end
    end

    // Frame sequencer with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ch         <= '0;
            acc        <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sample_tick && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        state <= ST_PHASE;
                        ch    <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_PHASE: state <= ST_MIX;
                ST_MIX: begin
                    if (ch == CH_BITS'(NUM_CH - 1)) begin
                        // Publish on entry to OUT so out_valid lands in the OUT cycle.
                        out_sample <= acc_sum;
                        out_valid  <= 1'b1;
                        acc        <= '0;
                        busy       <= 1'b0;
                        state      <= ST_OUT;
                    end else begin
                        acc   <= acc_sum;
                        ch    <= ch + 1'b1;
                        state <= ST_PHASE;
                    end
                end
                ST_OUT:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwls_multichannel_osc.sv
// -----------------------------------------------------------------------------
// tb_pwls_multichannel_osc
// Directed and randomized frames checked against a behavioural model that
// computes each mixed sample from the oscillator rules with integer math.
// -----------------------------------------------------------------------------
module tb_pwls_multichannel_osc;

    localparam int BITS     = 12;
    localparam int OCT_BITS = 3;
    localparam int NUM_CH   = 4;
    localparam int PB       = BITS + (1 << OCT_BITS) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sample_tick = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [1:0]        cfg_addr = '0;
    logic [13:0]       cfg_wdata = '0;
    logic signed [13:0] out_sample;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    int total = 0;
    int bad   = 0;

    int m_oct [NUM_CH];
    int m_man [NUM_CH];
    int m_amp [NUM_CH];
    int m_mode[NUM_CH];
    int m_ph  [NUM_CH];

    always #5 clk = ~clk;

    pwls_multichannel_osc #(.BITS(BITS), .OCT_BITS(OCT_BITS), .NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_tick(sample_tick),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int shape(input int ph, input int md, input int a);
        int p, t, w;
        p = ph >> (PB - BITS);
        case (md)
            0: w = p - 2048;
            1: begin
                t = (p < 2048) ? p : 4095 - p;
                w = 2 * t - 2048;
            end
            2: w = (p < 2048) ? 2047 : -2048;
            default: w = 0;
        endcase
        return (w * a) >>> 10;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_oct[i] = 0; m_man[i] = 0; m_amp[i] = 0; m_mode[i] = 3; m_ph[i] = 0;
        end
    endfunction

    function automatic void apply_wr(input int c, input int a, input int d);
        case (a)
            0: begin m_oct[c] = (d >> 11) & 7; m_man[c] = d & 2047; end
            1: m_amp[c]  = d & 1023;
            2: m_mode[c] = d & 3;
            default: m_ph[c] = 0;
        endcase
    endfunction

    // One frame; an optional write lands 'off' cycles after the tick.
    // Channel c's PHASE slot is at offset 2c+1; writes up to then count.
    function automatic int model_frame(input bit has_wr, input int off, input int wc,
                                       input int wa, input int wd);
        int  sum;
        bit  now, collide;
        sum = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            now     = has_wr && (wc == c) && (off <= 2 * c + 1);
            collide = now && (wa == 3) && (off == 2 * c + 1);
            if (now && !collide) apply_wr(wc, wa, wd);
            if (m_mode[c] != 3) m_ph[c] = (m_ph[c] + ((2048 + m_man[c]) << m_oct[c])) % (1 << PB);
            if (collide) m_ph[c] = 0;
            sum += shape(m_ph[c], m_mode[c], m_amp[c]);
        end
        if (has_wr && off > 2 * wc + 1) apply_wr(wc, wa, wd);
        return sum;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int c, input int a, input int d);
        cfg_we = 1'b1; cfg_ch = c[1:0]; cfg_addr = a[1:0]; cfg_wdata = d[13:0];
        @(posedge clk); #1;
        cfg_we = 1'b0;
        apply_wr(c, a, d);
    endtask

    // Tick at offset 0, optional config write at 'off', optional retick at 'rt'.
    task automatic run_frame(input string tag, input int expv, input bit has_wr, input int off,
                             input int wc, input int wa, input int wd, input int rt);
        int lat, nv;
        lat = -1; nv = 0;
        for (int k = 0; k < 12; k++) begin
            sample_tick = (k == 0) || (rt != 0 && k == rt);
            cfg_we      = has_wr && (k == off);
            cfg_ch      = wc[1:0];
            cfg_addr    = wa[1:0];
            cfg_wdata   = wd[13:0];
            @(posedge clk); #1;
            if (k == 0) chk({tag, "_busy_hi"}, int'(busy), 1);
            if (out_valid) begin
                nv++;
                lat = k + 1;
                chk({tag, "_sample"}, int'(out_sample), expv);
                chk({tag, "_busy_lo"}, int'(busy), 0);
            end
        end
        sample_tick = 1'b0;
        cfg_we      = 1'b0;
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_nvalid"}, nv, 1);
    endtask

    task automatic frame_lit(input string tag, input int lit);
        int e;
        e = model_frame(1'b0, 0, 0, 0, 0);
        run_frame(tag, lit, 1'b0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int e, nv, a, c, d, off;
        bit hw;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sample", int'(out_sample), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        frame_lit("empty", 0);
        chk("no_overrun", int'(overrun), 0);

        // Saw on ch0
        wr(0, 2, 0); wr(0, 0, 0); wr(0, 1, 1023);
        frame_lit("saw1", -2031);
        frame_lit("saw2", -2015);

        // Square on ch1, ch0 off
        wr(0, 2, 3); wr(1, 0, 7 << 11); wr(1, 1, 1023); wr(1, 2, 2);
        frame_lit("sq1", -2046);
        frame_lit("sq2", 2045);
        frame_lit("sq3", -2046);

        // Two and four channels mixed
        wr(0, 3, 0); wr(1, 3, 0); wr(0, 0, 7 << 11); wr(0, 2, 2);
        frame_lit("mix2a", -4092);
        frame_lit("mix2b", 4090);
        for (int i = 0; i < NUM_CH; i++) wr(i, 3, 0);
        for (int i = 2; i < NUM_CH; i++) begin
            wr(i, 0, 7 << 11); wr(i, 1, 1023); wr(i, 2, 2);
        end
        frame_lit("mix4", -8184);

        // Retick while busy is ignored but flagged
        e = model_frame(1'b0, 0, 0, 0, 0);
        run_frame("ovr", e, 1'b0, 0, 0, 0, 0, 4);
        chk("overrun_set", int'(overrun), 1);

        // ch3 amp written during ch2 PHASE slot: not yet used (ch3 PHASE later)
        e = model_frame(1'b1, 5, 3, 1, 500);
        run_frame("byp_amp", e, 1'b1, 5, 3, 1, 500, 0);
        // ch0 freq written in its own PHASE slot: bypassed into this frame
        e = model_frame(1'b1, 1, 0, 0, (3 << 11) | 100);
        run_frame("byp_freq", e, 1'b1, 1, 0, 0, (3 << 11) | 100, 0);
        // ch0 amp written after its MIX: takes effect next frame
        e = model_frame(1'b1, 3, 0, 1, 200);
        run_frame("late_amp", e, 1'b1, 3, 0, 1, 200, 0);
        chk("overrun_sticky", int'(overrun), 1);

        // Reset asserted mid-frame
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_sample", int'(out_sample), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_overrun", int'(overrun), 0);
        nv = 0;
        repeat (12) begin @(posedge clk); #1; if (out_valid) nv++; end
        chk("midrst_nvalid", nv, 0);
        rst_n = 1'b1;
        model_reset();
        repeat (3) begin @(posedge clk); #1; end
        chk("post_rst_idle", int'(busy), 0);
        frame_lit("post_rst", 0);

        // Phase reset colliding with ch0 PHASE slot
        wr(0, 2, 0); wr(0, 1, 1023);
        frame_lit("col_pre", -2031);
        e = model_frame(1'b1, 1, 0, 3, 0);
        run_frame("col", -2046, 1'b1, 1, 0, 3, 0, 0);
        frame_lit("col_post", -2031);

        // Randomized configurations and mid-frame writes
        for (int i = 0; i < NUM_CH; i++) begin
            wr(i, 0, $urandom_range(0, 16383));
            wr(i, 1, $urandom_range(0, 1023));
            wr(i, 2, $urandom_range(0, 2));
        end
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) begin
                c = $urandom_range(0, 3); a = $urandom_range(0, 3); d = $urandom_range(0, 16383);
                wr(c, a, d);
            end
            hw  = 1'($urandom_range(0, 1));
            off = $urandom_range(0, 10);
            c   = $urandom_range(0, 3);
            a   = $urandom_range(0, 3);
            d   = $urandom_range(0, 16383);
            e   = model_frame(hw, off, c, a, d);
            run_frame("rnd", e, hw, off, c, a, d, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
